// File: rtl/bsg_manycore_proc_tx_arbiter_if.sv
// Bundle of request, endpoint, credit and fence signals between the tile request
// sources and the outbound arbiter.
interface bsg_manycore_proc_tx_arbiter_if #(
    parameter int num_chan_p        = 3,
    parameter int packet_width_p    = 32,
    parameter int max_out_credits_p = 32
);
    localparam int credit_w_lp  = $clog2(max_out_credits_p + 1);
    localparam int chan_id_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;

    // Handshake: a channel's packet is consumed in the cycle its req_yumi_o bit is 1,
    // which happens only when out_v_o & out_ready_i; out_v_o never looks at out_ready_i.
    logic [num_chan_p-1:0]                req_v_i;
    logic [num_chan_p*packet_width_p-1:0] req_packet_i;
    logic [num_chan_p-1:0]                req_yumi_o;
    logic [packet_width_p-1:0]            out_packet_o;
    logic                                 out_v_o;
    logic                                 out_ready_i;
    logic                                 credit_v_i;
    logic [chan_id_w_lp-1:0]              credit_chan_i;
    logic                                 fence_req_i;
    logic                                 fence_done_o;
    logic [credit_w_lp-1:0]               out_credits_o;
    logic [num_chan_p*credit_w_lp-1:0]    chan_outstanding_o;
    logic [1:0]                           state_o;

    modport slave (
        input  req_v_i, req_packet_i, out_ready_i, credit_v_i, credit_chan_i, fence_req_i,
        output req_yumi_o, out_packet_o, out_v_o, fence_done_o, out_credits_o,
        chan_outstanding_o, state_o
    );

    modport master (
        output req_v_i, req_packet_i, out_ready_i, credit_v_i, credit_chan_i, fence_req_i,
        input  req_yumi_o, out_packet_o, out_v_o, fence_done_o, out_credits_o,
        chan_outstanding_o, state_o
    );
endinterface

// File: rtl/bsg_manycore_proc_tx_arbiter.sv
// Round-robin merge of per-channel requests onto one endpoint port, with a global
// credit pool, per-channel outstanding limits and a fence/drain state machine.
module bsg_manycore_proc_tx_arbiter #(
    parameter int num_chan_p        = 3,
    parameter int packet_width_p    = 32,
    parameter int max_out_credits_p = 32,
    parameter int chan_limit_p      = 16
) (
    input logic                          clk_i,
    input logic                          reset_n_i,
    bsg_manycore_proc_tx_arbiter_if.slave bus
);
    localparam int credit_w_lp  = $clog2(max_out_credits_p + 1);
    localparam int chan_id_w_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam logic [credit_w_lp-1:0]  max_c   = credit_w_lp'(max_out_credits_p);
    localparam logic [credit_w_lp-1:0]  limit_c = credit_w_lp'(chan_limit_p);
    localparam logic [credit_w_lp-1:0]  one_c   = credit_w_lp'(1);
    localparam logic [chan_id_w_lp-1:0] last_c  = chan_id_w_lp'(num_chan_p - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FENCED = 2'd2
    } state_e;

    state_e                  state_r, state_n;
    logic [credit_w_lp-1:0]  out_credits_r, out_credits_n;
    logic [credit_w_lp-1:0]  chan_out_r [num_chan_p];
    logic [credit_w_lp-1:0]  chan_out_n [num_chan_p];
    logic [chan_id_w_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [chan_id_w_lp-1:0] grant;
    logic [num_chan_p-1:0]   eligible;
    logic [num_chan_p-1:0]   chan_ret;
    logic                    found;
    logic                    out_v;
    logic                    send;
    logic                    chan_ok;
    logic                    ret_global;
    logic                    ret_legal;
    logic [credit_w_lp-1:0]  sel_cnt;

    always_comb begin
        eligible = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            eligible[c] = bus.req_v_i[c] && (chan_out_r[c] < limit_c)
                          && (out_credits_r != '0) && (state_r == ST_RUN);
        end
    end

    // First eligible channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < num_chan_p; i++) begin
            idx = int'(rr_ptr_r) + i;
            if (idx >= num_chan_p) idx = idx - num_chan_p;
            if (!found && eligible[chan_id_w_lp'(idx)]) begin
                found = 1'b1;
                grant = chan_id_w_lp'(idx);
            end
        end
    end

    assign out_v = |eligible;
    assign send  = out_v & bus.out_ready_i;

    always_comb begin
        bus.req_yumi_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            bus.req_yumi_o[c] = send && (grant == chan_id_w_lp'(c));
        end
    end

    assign bus.out_v_o      = out_v;
    assign bus.out_packet_o = bus.req_packet_i[int'(grant)*packet_width_p +: packet_width_p];

    // Illegal returns leave the affected counter alone instead of wrapping.
    always_comb begin
        chan_ok  = (int'(bus.credit_chan_i) < num_chan_p);
        sel_cnt  = '0;
        chan_ret = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            if (bus.credit_chan_i == chan_id_w_lp'(c)) sel_cnt = chan_out_r[c];
            chan_ret[c] = bus.credit_v_i && chan_ok && (bus.credit_chan_i == chan_id_w_lp'(c))
                          && (chan_out_r[c] != '0);
        end
        ret_global = bus.credit_v_i && (out_credits_r != max_c);
        ret_legal  = chan_ok && (out_credits_r != max_c) && (sel_cnt != '0);
    end

    always_comb begin
        out_credits_n = out_credits_r;
        if (send && !ret_global)      out_credits_n = out_credits_r - one_c;
        else if (!send && ret_global) out_credits_n = out_credits_r + one_c;
        for (int c = 0; c < num_chan_p; c++) begin
            chan_out_n[c] = chan_out_r[c];
            if ((send && grant == chan_id_w_lp'(c)) && !chan_ret[c])
                chan_out_n[c] = chan_out_r[c] + one_c;
            else if (!(send && grant == chan_id_w_lp'(c)) && chan_ret[c])
                chan_out_n[c] = chan_out_r[c] - one_c;
        end
        rr_ptr_n = rr_ptr_r;
        if (send) rr_ptr_n = (grant == last_c) ? '0 : grant + chan_id_w_lp'(1);
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            ST_RUN:    if (bus.fence_req_i) state_n = ST_DRAIN;
            ST_DRAIN: begin
                if (!bus.fence_req_i)           state_n = ST_RUN;
                else if (out_credits_n == max_c) state_n = ST_FENCED;
            end
            ST_FENCED: if (!bus.fence_req_i) state_n = ST_RUN;
            default:   state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_RUN;
            out_credits_r <= max_c;
            rr_ptr_r      <= '0;
            for (int c = 0; c < num_chan_p; c++) chan_out_r[c] <= '0;
        end else begin
            state_r       <= state_n;
            out_credits_r <= out_credits_n;
            rr_ptr_r      <= rr_ptr_n;
            for (int c = 0; c < num_chan_p; c++) chan_out_r[c] <= chan_out_n[c];
        end
    end

    always_comb begin
        bus.chan_outstanding_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            bus.chan_outstanding_o[c*credit_w_lp +: credit_w_lp] = chan_out_r[c];
        end
    end

    assign bus.out_credits_o = out_credits_r;
    assign bus.fence_done_o  = (state_r == ST_FENCED);
    assign bus.state_o       = state_r;

    credit_return_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.credit_v_i |-> ret_legal);
endmodule

// File: tb/tb_bsg_manycore_proc_tx_arbiter.sv
// Bench for the outbound arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural credit/fence model.
module tb_bsg_manycore_proc_tx_arbiter;
    localparam int N   = 3;
    localparam int W   = 16;
    localparam int MAX = 8;
    localparam int LIM = 3;
    localparam int CW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] exp_q[$];

    bsg_manycore_proc_tx_arbiter_if #(.num_chan_p(N), .packet_width_p(W), .max_out_credits_p(MAX)) bus ();

    bsg_manycore_proc_tx_arbiter #(
        .num_chan_p(N), .packet_width_p(W), .max_out_credits_p(MAX), .chan_limit_p(LIM)
    ) dut (
        .clk_i(clk),
        .reset_n_i(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: credit pool, per-channel outstanding, rr pointer, fence mode.
    int m_credits;
    int m_out [N];
    int m_rr;
    int m_fence;  // 0 running, 1 draining, 2 fenced

    function automatic void model_grant(output bit v, output int g);
        v = 1'b0;
        g = 0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_rr + i) % N;
            if (!v && bus.req_v_i[c] && m_out[c] < LIM && m_credits > 0 && m_fence == 0) begin
                v = 1'b1;
                g = c;
            end
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_credits = MAX;
            for (int c = 0; c < N; c++) m_out[c] = 0;
            m_rr = 0;
            m_fence = 0;
        end else begin
            bit v;
            int g;
            model_grant(v, g);
            if (bus.credit_v_i) begin
                if (m_credits < MAX) m_credits++;
                if (int'(bus.credit_chan_i) < N && m_out[bus.credit_chan_i] > 0)
                    m_out[bus.credit_chan_i]--;
            end
            if (v && bus.out_ready_i) begin
                m_credits--;
                m_out[g]++;
                m_rr = (g + 1) % N;
            end
            case (m_fence)
                0: if (bus.fence_req_i) m_fence = 1;
                1: if (!bus.fence_req_i) m_fence = 0; else if (m_credits == MAX) m_fence = 2;
                default: if (!bus.fence_req_i) m_fence = 0;
            endcase
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            bit v;
            int g;
            logic [31:0] ey;
            model_grant(v, g);
            ey = (v && bus.out_ready_i) ? (32'd1 << g) : 32'd0;
            chk("out_v", 32'(bus.out_v_o), 32'(v));
            chk("yumi", 32'(bus.req_yumi_o), ey);
            if (v) chk("packet", 32'(bus.out_packet_o), 32'(bus.req_packet_i[g*W +: W]));
            chk("credits", 32'(bus.out_credits_o), 32'(m_credits));
            for (int c = 0; c < N; c++)
                chk("chan_out", 32'(bus.chan_outstanding_o[c*CW +: CW]), 32'(m_out[c]));
            chk("fence_done", 32'(bus.fence_done_o), 32'(m_fence == 2));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle's inputs; literal checks may follow before the next cycle().
    task automatic apply(logic [N-1:0] v, logic rdy, logic cv, int cc, logic fr);
        bus.req_v_i = v;
        for (int c = 0; c < N; c++) bus.req_packet_i[c*W +: W] = W'($urandom);
        bus.out_ready_i   = rdy;
        bus.credit_v_i    = cv;
        bus.credit_chan_i = 2'(cc);
        bus.fence_req_i   = fr;
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        apply('0, 1'b0, 1'b0, 0, 1'b0);
        #7;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] chan_cnt(int c);
        return 32'(bus.chan_outstanding_o[c*CW +: CW]);
    endfunction

    logic fr_r;

    initial begin
        do_reset();
        apply('0, 1'b1, 1'b0, 0, 1'b0);
        chk("reset_credits", 32'(bus.out_credits_o), MAX);
        chk("reset_out_v", 32'(bus.out_v_o), 0);
        chk("reset_fence_done", 32'(bus.fence_done_o), 0);
        chk("reset_chan_out", 32'(bus.chan_outstanding_o), 0);

        // Round robin across three busy channels.
        for (int i = 0; i < 6; i++) exp_q.push_back(32'd1 << (i % 3));
        for (int i = 0; i < 6; i++) begin
            apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
            chk("rr_yumi", 32'(bus.req_yumi_o), exp_q.pop_front());
            cycle();
        end
        apply('0, 1'b1, 1'b0, 0, 1'b0);
        chk("rr_credits", 32'(bus.out_credits_o), MAX - 6);

        // Per-channel limit, then one return frees one more send.
        do_reset();
        for (int i = 0; i < LIM; i++) begin
            apply(3'b010, 1'b1, 1'b0, 0, 1'b0);
            chk("limit_yumi", 32'(bus.req_yumi_o), 32'b010);
            cycle();
        end
        apply(3'b010, 1'b1, 1'b0, 0, 1'b0);
        chk("limit_block", 32'(bus.out_v_o), 0);
        chk("limit_count", chan_cnt(1), LIM);
        apply(3'b010, 1'b1, 1'b1, 1, 1'b0);
        chk("limit_ret_cycle", 32'(bus.out_v_o), 0);
        cycle();
        apply(3'b010, 1'b1, 1'b0, 0, 1'b0);
        chk("limit_resend", 32'(bus.req_yumi_o), 32'b010);
        cycle();
        apply(3'b010, 1'b1, 1'b0, 0, 1'b0);
        chk("limit_reblock", 32'(bus.out_v_o), 0);

        // Send and return on the same channel in one cycle.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(3'b001, 1'b1, 1'b0, 0, 1'b0);
            cycle();
        end
        apply(3'b001, 1'b1, 1'b1, 0, 1'b0);
        chk("simul_yumi", 32'(bus.req_yumi_o), 32'b001);
        cycle();
        apply('0, 1'b1, 1'b0, 0, 1'b0);
        chk("simul_credits", 32'(bus.out_credits_o), MAX - 2);
        chk("simul_chan0", chan_cnt(0), 2);

        // Fence with four outstanding.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
            cycle();
        end
        apply('0, 1'b1, 1'b0, 0, 1'b1);
        cycle();
        apply(3'b111, 1'b1, 1'b0, 0, 1'b1);
        chk("drain_no_grant", 32'(bus.out_v_o), 0);
        for (int i = 0; i < 4; i++) begin
            apply(3'b111, 1'b1, 1'b1, i % 3, 1'b1);
            chk("drain_out_v", 32'(bus.out_v_o), 0);
            chk("drain_not_done", 32'(bus.fence_done_o), 0);
            cycle();
        end
        apply(3'b111, 1'b1, 1'b0, 0, 1'b1);
        chk("fence_done_rise", 32'(bus.fence_done_o), 1);
        chk("fence_credits", 32'(bus.out_credits_o), MAX);
        cycle();
        apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
        chk("fenced_no_grant", 32'(bus.out_v_o), 0);
        cycle();
        apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
        chk("resume_yumi", 32'(bus.req_yumi_o), 32'b010);
        chk("resume_done_low", 32'(bus.fence_done_o), 0);
        cycle();

        // Fence with nothing outstanding: done two cycles after the request.
        do_reset();
        apply('0, 1'b1, 1'b0, 0, 1'b1);
        chk("idle_fence_c0", 32'(bus.fence_done_o), 0);
        cycle();
        apply('0, 1'b1, 1'b0, 0, 1'b1);
        chk("idle_fence_c1", 32'(bus.fence_done_o), 0);
        cycle();
        apply('0, 1'b1, 1'b0, 0, 1'b1);
        chk("idle_fence_c2", 32'(bus.fence_done_o), 1);
        cycle();

        // Exhaust the global pool, then one return allows exactly one grant.
        do_reset();
        for (int i = 0; i < MAX; i++) begin
            apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
            cycle();
        end
        apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
        chk("exhaust_out_v", 32'(bus.out_v_o), 0);
        chk("exhaust_credits", 32'(bus.out_credits_o), 0);
        apply(3'b111, 1'b1, 1'b1, 0, 1'b0);
        chk("exhaust_ret_cycle", 32'(bus.out_v_o), 0);
        cycle();
        apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
        chk("exhaust_one_grant", 32'(bus.req_yumi_o), 32'b100);
        cycle();
        apply(3'b111, 1'b1, 1'b0, 0, 1'b0);
        chk("exhaust_again", 32'(bus.out_v_o), 0);
        cycle();

        // Random traffic with a mid-run asynchronous reset.
        do_reset();
        fr_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int c;
            logic cv;
            if ($urandom_range(0, 63) == 0) fr_r = ~fr_r;
            c  = $urandom_range(0, N - 1);
            cv = (m_out[c] > 0) && ($urandom_range(0, 1) == 1);
            apply(N'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, cv, c, fr_r);
            if (n == 1500) begin
                reset_n = 1'b0;
                #1;
                chk("midreset_credits", 32'(bus.out_credits_o), MAX);
                chk("midreset_fence_done", 32'(bus.fence_done_o), 0);
                chk("midreset_chan_out", 32'(bus.chan_outstanding_o), 0);
                @(posedge clk);
                #1;
                reset_n = 1'b1;
                bus.credit_v_i = 1'b0;
                fr_r = 1'b0;
                bus.fence_req_i = 1'b0;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
